sprite_motion: RTL and testbench

Per-frame position generator for the 720p sprite path. It drives the centre coordinate (x_out, y_out) consumed by the circle sprite renderer. Once per frame, during vertical blanking, it advances the centre by a runtime speed and reflects off the active-area edges so the whole circle stays on screen. Outputs never change during active video.

---
 rtl/video_pkg.sv | 16 +
 rtl/axis_reflect.sv | 65 ++++++
 rtl/sprite_motion.sv | 94 +++++++++
 tb/tb_sprite_motion.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared 720p timing constants and the motion sequencer state type.
package video_pkg;

   localparam int H_ACTIVE_DEF = 1280;
   localparam int V_ACTIVE_DEF = 720;
   localparam int RADIUS_DEF   = 64;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_LATCH,
      ST_STEP_X,
      ST_STEP_Y,
      ST_DONE
   } motion_state_t;

endpackage

// File: rtl/axis_reflect.sv
// One sprite axis: holds position and direction, and on step_i advances by speed_i,
// folding back into [MIN, MAX] when the candidate overshoots the bound.
module axis_reflect #(
   parameter int WIDTH = 11,
   parameter int MIN   = 64,
   parameter int MAX   = 1215,
   parameter int INIT  = 640
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             step_i,
   input  logic             hold_i,
   input  logic [3:0]       speed_i,
   output logic [WIDTH-1:0] pos_o,
   output logic             hit_o
);

   // Two spare bits: one for sign (underflow below 0), one for the 2*MAX fold term.
   localparam int CW = WIDTH + 2;
   localparam logic signed [CW-1:0] MIN_S = CW'(MIN);
   localparam logic signed [CW-1:0] MAX_S = CW'(MAX);

   logic [WIDTH-1:0]     pos_q, pos_d;
   logic                 dir_q, dir_d;
   logic                 hit_q, hit_d;
   logic signed [CW-1:0] pos_s, spd_s, cand, fold;

   always_comb begin
      pos_s = $signed({2'b00, pos_q});
      spd_s = $signed({{(CW-4){1'b0}}, speed_i});
      cand  = dir_q ? (pos_s + spd_s) : (pos_s - spd_s);
      fold  = cand;
      pos_d = pos_q;
      dir_d = dir_q;
      hit_d = 1'b0;
      if (step_i && !hold_i) begin
         if (dir_q && (cand > MAX_S)) begin
            fold  = MAX_S + MAX_S - cand;
            dir_d = 1'b0;
            hit_d = 1'b1;
         end else if (!dir_q && (cand < MIN_S)) begin
            fold  = MIN_S + MIN_S - cand;
            dir_d = 1'b1;
            hit_d = 1'b1;
         end
         pos_d = WIDTH'(fold);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pos_q <= WIDTH'(INIT);
         dir_q <= 1'b1;
         hit_q <= 1'b0;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
         hit_q <= hit_d;
      end
   end

   assign pos_o = pos_q;
   assign hit_o = hit_q;

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite centre generator: one bounded, reflecting step per frame,
// sequenced at the start of vertical blanking so outputs never move in active video.
module sprite_motion
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int RADIUS   = RADIUS_DEF
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [3:0]  speed_in,
   input  logic        pause_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        hit_x_out,
   output logic        hit_y_out,
   output logic        frame_done_out
);

   motion_state_t state_q, state_d;
   logic [3:0]    speed_q;
   logic          pause_q;
   logic          frame_done_q;
   logic          trigger;
   logic          hold;

   assign trigger = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
   assign hold    = pause_q || (speed_q == 4'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT:   if (trigger) state_d = ST_LATCH;
         ST_LATCH:  state_d = ST_STEP_X;
         ST_STEP_X: state_d = ST_STEP_Y;
         ST_STEP_Y: state_d = ST_DONE;
         ST_DONE:   state_d = ST_WAIT;
         default:   state_d = ST_WAIT;
      endcase
   end

   // frame_done is registered off STEP_Y so it is high exactly while in DONE.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= ST_WAIT;
         speed_q      <= 4'd0;
         pause_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= (state_q == ST_STEP_Y);
         if (state_q == ST_LATCH) begin
            speed_q <= speed_in;
            pause_q <= pause_in;
         end
      end
   end

   axis_reflect #(
      .WIDTH (11),
      .MIN   (RADIUS),
      .MAX   (H_ACTIVE - 1 - RADIUS),
      .INIT  (H_ACTIVE / 2)
   ) u_axis_x (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .step_i  (state_q == ST_STEP_X),
      .hold_i  (hold),
      .speed_i (speed_q),
      .pos_o   (x_out),
      .hit_o   (hit_x_out)
   );

   axis_reflect #(
      .WIDTH (10),
      .MIN   (RADIUS),
      .MAX   (V_ACTIVE - 1 - RADIUS),
      .INIT  (V_ACTIVE / 2)
   ) u_axis_y (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .step_i  (state_q == ST_STEP_Y),
      .hold_i  (hold),
      .speed_i (speed_q),
      .pos_o   (y_out),
      .hit_o   (hit_y_out)
   );

   assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Randomized frame-level bench for sprite_motion against a bouncing-ball reference model.
module tb_sprite_motion;

   localparam int XMIN = 64;
   localparam int XMAX = 1215;
   localparam int YMIN = 64;
   localparam int YMAX = 655;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [3:0]  speed_in;
   logic        pause_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        hit_x_out;
   logic        hit_y_out;
   logic        frame_done_out;

   int checks   = 0;
   int failures = 0;

   // Reference state: centre position and +1/-1 velocity sign per axis.
   int mx, my, mdx, mdy;

   sprite_motion dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .speed_in       (speed_in),
      .pause_in       (pause_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .hit_x_out      (hit_x_out),
      .hit_y_out      (hit_y_out),
      .frame_done_out (frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mx = 640; my = 360; mdx = 1; mdy = 1;
   endtask

   // Ball physics: move by v*speed; if past a wall, mirror about that wall and reverse.
   task automatic bounce(input int p, input int d, input int spd, input int lo, input int hi,
                         output int np, output int nd, output int hit);
      int c;
      c   = p + d * spd;
      np  = c;
      nd  = d;
      hit = 0;
      if (c > hi) begin
         np = hi - (c - hi); nd = -d; hit = 1;
      end else if (c < lo) begin
         np = lo + (lo - c); nd = -d; hit = 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         hcount_in = 11'($urandom_range(0, 1649));
         vcount_in = 10'($urandom_range(0, 719));
         speed_in  = 4'($urandom);
         pause_in  = 1'($urandom);
         check("idle_x", int'(x_out), mx);
         check("idle_y", int'(y_out), my);
         check("idle_fd", int'(frame_done_out), 0);
      end
   endtask

   task automatic run_frame(input int spd, input int pse, input int hold, input int rst_mid);
      int ox, oy, nx, ny, ndx, ndy, hx, hy;
      ox = mx; oy = my;
      nx = mx; ny = my; ndx = mdx; ndy = mdy; hx = 0; hy = 0;
      if (pse == 0 && spd != 0) begin
         bounce(mx, mdx, spd, XMIN, XMAX, nx, ndx, hx);
         bounce(my, mdy, spd, YMIN, YMAX, ny, ndy, hy);
      end
      @(negedge clk_in);
      hcount_in = 11'd0;
      vcount_in = 10'd720;
      speed_in  = 4'(spd);
      pause_in  = 1'(pse);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         case (k)
            1, 2: begin
               check("pre_x", int'(x_out), ox);
               check("pre_y", int'(y_out), oy);
               check("pre_hx", int'(hit_x_out), 0);
               check("pre_fd", int'(frame_done_out), 0);
            end
            3: begin
               check("stepx_x", int'(x_out), nx);
               check("stepx_hx", int'(hit_x_out), hx);
               check("stepx_y", int'(y_out), oy);
               check("stepx_hy", int'(hit_y_out), 0);
               check("stepx_fd", int'(frame_done_out), 0);
            end
            4: begin
               check("stepy_x", int'(x_out), nx);
               check("stepy_hx", int'(hit_x_out), 0);
               check("stepy_y", int'(y_out), ny);
               check("stepy_hy", int'(hit_y_out), hy);
               check("stepy_fd", int'(frame_done_out), 1);
            end
            default: begin
               check("done_fd", int'(frame_done_out), 0);
               check("done_hy", int'(hit_y_out), 0);
               check("done_y", int'(y_out), ny);
            end
         endcase
         if (k == hold) vcount_in = 10'd725;
         // Inputs only matter at LATCH; scramble them once it has passed.
         if (k == 2) begin
            speed_in = 4'($urandom);
            pause_in = 1'($urandom);
         end
         if (k == 3 && rst_mid != 0) begin
            vcount_in = 10'd725;
            rst_in = 1'b0;
            #1;
            check("rst_x", int'(x_out), 640);
            check("rst_y", int'(y_out), 360);
            check("rst_hx", int'(hit_x_out), 0);
            check("rst_hy", int'(hit_y_out), 0);
            check("rst_fd", int'(frame_done_out), 0);
            @(negedge clk_in);
            rst_in = 1'b1;
            model_reset();
            $display("frame spd=%0d pause=%0d reset mid-sequence x=%0d y=%0d", spd, pse, x_out, y_out);
            return;
         end
      end
      mx = nx; my = ny; mdx = ndx; mdy = ndy;
      $display("frame spd=%0d pause=%0d hold=%0d x=%0d y=%0d hx=%0d hy=%0d",
               spd, pse, hold, x_out, y_out, hx, hy);
   endtask

   initial begin
      rst_in    = 1'b0;
      hcount_in = 11'd5;
      vcount_in = 10'd100;
      speed_in  = 4'd0;
      pause_in  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_in);
      check("reset_x", int'(x_out), 640);
      check("reset_y", int'(y_out), 360);
      check("reset_hx", int'(hit_x_out), 0);
      check("reset_hy", int'(hit_y_out), 0);
      check("reset_fd", int'(frame_done_out), 0);
      rst_in = 1'b1;
      idle(3);

      run_frame(4, 0, 1, 0);
      check("first_x", int'(x_out), 644);
      check("first_y", int'(y_out), 364);
      idle(4);
      run_frame(7, 1, 1, 0);
      idle(4);
      run_frame(0, 0, 2, 0);
      idle(4);
      run_frame(3, 0, 5, 0);
      idle(6);

      for (int i = 0; i < 300; i++) begin
         int spd, pse, hold;
         spd  = $urandom_range(0, 15);
         pse  = ($urandom_range(0, 7) == 0) ? 1 : 0;
         hold = $urandom_range(1, 5);
         run_frame(spd, pse, hold, (i == 150) ? 1 : 0);
         idle($urandom_range(1, 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
